// File: rtl/ser_pkg.sv
// Shared FSM state type, width defaults and counter sizing for tap_serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;
  localparam int SER_GAP_MAX   = 15;

  // One counter serves both the bit count and the gap count, so it must hold either range.
  function automatic int ser_cnt_width(input int width);
    int bw;
    int gw;
    bw = $clog2(width + 1);
    gw = $clog2(SER_GAP_MAX + 1);
    return (bw > gw) ? bw : gw;
  endfunction

endpackage

// File: rtl/ser_bitcnt.sv
// Loadable down-counter shared by the frame bit count and the inter-frame gap count.
module ser_bitcnt import ser_pkg::*; #(
  parameter int CW = $clog2(SER_GAP_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tap_serializer.sv
// Parallel-to-serial front end for a tapped delay line, MSB first, optional idle gap.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module tap_serializer import ser_pkg::*; #(
  parameter int WIDTH = SER_WIDTH_DEF,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start
);

`ifdef SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int            CW         = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0] FRAME_LOAD = CW'(WIDTH + PAR_BITS - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? (GAP - 1) : 0);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             transfer;
  logic             data_bit;

  // Counter holds cycles remaining minus one, so zero marks the last cycle of a phase.
  ser_bitcnt #(.CW(CW)) u_bitcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (state_reg != IDLE),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign din_ready = (state_reg == IDLE) || ((GAP == 0) && (state_reg == SHIFT) && cnt_zero);
  assign transfer  = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = FRAME_LOAD;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          state_next = SHIFT;
          cnt_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          if (GAP > 0) begin
            state_next   = ser_pkg::GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else if (transfer) begin
            cnt_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      ser_pkg::GAP: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
    end else if (transfer) begin
      shreg_reg <= din;
    end else if (state_reg == SHIFT) begin
      shreg_reg <= shreg_reg << 1;
    end
  end

`ifdef SER_PARITY_EN
  logic par_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (transfer) begin
      par_reg <= ^din;
    end
  end

  // The final SHIFT cycle carries parity instead of data.
  assign data_bit = cnt_zero ? par_reg : shreg_reg[WIDTH-1];
`else
  assign data_bit = shreg_reg[WIDTH-1];
`endif

  assign sout_valid  = (state_reg == SHIFT);
  assign sout        = sout_valid && data_bit;
  assign frame_start = sout_valid && (cnt == FRAME_LOAD);

endmodule

// File: doc/tap_serializer.md
TAP_SERIALIZER -- requirements
Module: tap_serializer

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: data bits per word.
- REQ-002 SHALL have parameter GAP, default 0: idle cycles inserted between frames (0..15).
- REQ-003 SHALL have port clk  input  1  the only clock; all state changes on the rising edge.
- REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
- REQ-005 SHALL have port din  input  WIDTH  parallel word to transmit.
- REQ-006 SHALL have port din_valid  input  1  din holds a valid word.
- REQ-007 SHALL have port din_ready  output  1  block will accept din this cycle.
- REQ-008 SHALL have port sout  output  1  serial bit that feeds the tapped delay line.
- REQ-009 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
- REQ-010 SHALL have port frame_start  output  1  high only on a frame's first bit.

Function
- REQ-011 SHALL define a transfer as din_valid && din_ready on a rising edge; on a transfer it SHALL capture din into a shift register.
- REQ-012 SHALL use the FSM states IDLE, SHIFT and GAP, with transitions as given in REQ-013 to REQ-017.
- REQ-013 SHALL go IDLE->SHIFT on a transfer; with no transfer it SHALL stay in IDLE.
- REQ-014 In SHIFT it SHALL drive sout = the current MSB of the shift register and sout_valid=1, then shift left one bit per cycle, for WIDTH cycles starting the cycle after the transfer (latency 1).
- REQ-015 SHALL assert frame_start only in the first SHIFT cycle of each frame.
- REQ-016 After the last bit it SHALL go SHIFT->GAP when GAP>0 and hold GAP for exactly GAP cycles with sout=0 and sout_valid=0, then go GAP->IDLE.
- REQ-017 When GAP==0 it SHALL go SHIFT->IDLE, or SHIFT->SHIFT if a new transfer happens in the last bit cycle.
- REQ-018 SHALL assert din_ready in IDLE, and also in the last bit cycle of SHIFT when GAP==0, so back-to-back frames have no idle cycle; it SHALL deassert din_ready in every other cycle.
- REQ-019 SHALL ignore din and din_valid while din_ready=0; a held din_valid SHALL be accepted on the first cycle din_ready=1.
- REQ-020 SHALL use a bit counter of width $clog2(WIDTH+1) that wraps to 0 at frame end; it SHALL never drive more or fewer than WIDTH data bits per frame.
- REQ-021 SHALL drive sout=0 whenever sout_valid=0.

Reset
- REQ-022 On rst_n low it SHALL immediately enter IDLE with din_ready=1 after release, and sout=0, sout_valid=0, frame_start=0.
- REQ-023 Reset mid-frame SHALL discard the in-flight word with no partial resumption; the first edge after release SHALL behave as IDLE.

Configuration
- REQ-024 With SER_PARITY_EN defined it SHALL append one even-parity bit (XOR of the captured word) after the data bits, with sout_valid=1 and frame_start=0, so a frame lasts WIDTH+1 cycles; the REQ-018 early-ready cycle SHALL then be the parity cycle.
- REQ-025 Without SER_PARITY_EN the parity logic SHALL be absent and a frame SHALL be exactly WIDTH cycles.

Structure
- REQ-026 Package ser_pkg SHALL hold the state enum (IDLE, SHIFT, GAP), the default WIDTH constant 8 and the maximum GAP constant 15.
- REQ-027 Sub-module ser_bitcnt SHALL be the natural split: a loadable down-counter reused for both the bit count and the gap count.

Verification
- REQ-028 Reset, then din=8'hA5 with din_valid for 1 cycle, GAP=0 -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 after the transfer, frame_start only on cycle 1, din_ready=1 on cycle 8.
- REQ-029 din_valid held high with 8'h3C then 8'hC3, GAP=0 -> 16 contiguous sout_valid cycles 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1 and two frame_start pulses 8 cycles apart.
- REQ-030 GAP=2, two words -> exactly 2 cycles with sout_valid=0 and din_ready=0 between frames, then din_ready=1.
- REQ-031 SER_PARITY_EN defined, din=8'hA5 then 8'h07 -> 9-bit frames with parity bit 0 then 1.
- REQ-032 rst_n pulsed low during bit 3 of 8'hFF -> sout=0 and sout_valid=0 immediately, no further bits, din_ready=1 on release.
- REQ-033 din_valid toggled while din_ready=0 with changing din -> transmitted bits match only the word captured at the transfer.
